// File: rtl/mem_port_arbiter.sv
// Arbiter that shares a single-port unified memory between instruction fetch and the
// MEM stage. Data has priority, fetch is protected from starvation, and a stalled memory is timed out.
module mem_port_arbiter #(
    parameter int AW         = 10,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ready,
    output logic [DW-1:0] if_rdata,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic          dm_ready,
    output logic [DW-1:0] dm_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          timeout_err
);

    localparam int SW = $clog2(STARVE_MAX + 2);
    localparam int CW = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;

    state_t        state_q, state_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          if_ready_q, if_ready_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic          dm_ready_q, dm_ready_d;
    logic [DW-1:0] dm_rdata_q, dm_rdata_d;
    logic          busy_q, busy_d;
    logic          timeout_err_q, timeout_err_d;
    logic [SW-1:0] streak_q, streak_d;
    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic          if_elig, dm_elig, finish, timed_out;
    logic [DW-1:0] ret_data;

    // A requester is not eligible in the cycle its ready pulse is showing.
    assign if_elig   = if_req && !if_ready_q;
    assign dm_elig   = dm_req && !dm_ready_q;
    assign timed_out = !mem_ready && (tmo_cnt_q == CW'(TIMEOUT));
    assign ret_data  = mem_ready ? mem_rdata : '0;

    always_comb begin
        state_d       = state_q;
        mem_req_d     = 1'b0;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        if_ready_d    = 1'b0;
        if_rdata_d    = if_rdata_q;
        dm_ready_d    = 1'b0;
        dm_rdata_d    = dm_rdata_q;
        timeout_err_d = timeout_err_q;
        streak_d      = streak_q;
        tmo_cnt_d     = tmo_cnt_q;
        finish        = 1'b0;

        case (state_q)
            IDLE: begin
                if (dm_elig && !(if_elig && streak_q == SW'(STARVE_MAX))) begin
                    state_d     = DM_WAIT;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_we;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    streak_d    = if_elig ? streak_q + SW'(1) : '0;
                    tmo_cnt_d   = '0;
                end else if (if_elig) begin
                    state_d    = IF_WAIT;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = if_addr;
                    streak_d   = '0;
                    tmo_cnt_d  = '0;
                end
            end
            IF_WAIT, DM_WAIT: begin
                // The strobe cycle itself never completes or counts toward the timeout.
                if (!mem_req_q) begin
                    if (mem_ready || timed_out) begin
                        finish = 1'b1;
                    end else begin
                        tmo_cnt_d = tmo_cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (finish) begin
            state_d = IDLE;
            if (timed_out) begin
                timeout_err_d = 1'b1;
            end
            if (state_q == IF_WAIT) begin
                if_ready_d = 1'b1;
                if_rdata_d = ret_data;
            end else begin
                dm_ready_d = 1'b1;
                if (!mem_we_q) begin
                    dm_rdata_d = ret_data;
                end
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            if_ready_q    <= 1'b0;
            if_rdata_q    <= '0;
            dm_ready_q    <= 1'b0;
            dm_rdata_q    <= '0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            streak_q      <= '0;
            tmo_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            if_ready_q    <= if_ready_d;
            if_rdata_q    <= if_rdata_d;
            dm_ready_q    <= dm_ready_d;
            dm_rdata_q    <= dm_rdata_d;
            busy_q        <= busy_d;
            timeout_err_q <= timeout_err_d;
            streak_q      <= streak_d;
            tmo_cnt_q     <= tmo_cnt_d;
        end
    end

    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign if_ready    = if_ready_q;
    assign if_rdata    = if_rdata_q;
    assign dm_ready    = dm_ready_q;
    assign dm_rdata    = dm_rdata_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a transaction-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic and memory behaviour.
module tb_mem_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SM = 2;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req, dm_req, dm_we, mem_ready;
    logic [AW-1:0] if_addr, dm_addr;
    logic [DW-1:0] dm_wdata, mem_rdata;
    logic          if_ready, dm_ready, mem_req, mem_we, busy, timeout_err;
    logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SM), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, tracked by who owns it and its age.
    bit          model_ok = 1'b0;
    bit          m_active = 1'b0;
    int          m_who = 0;
    int          m_age = 0;
    int          m_streak = 0;
    bit          m_err = 0, m_if_ready = 0, m_dm_ready = 0, m_mem_req = 0, m_mem_we = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_wdata = '0, m_if_rdata = '0, m_dm_rdata = '0;

    task automatic modelFinish(input logic [DW-1:0] val, input bit tmo);
        m_active = 1'b0;
        if (m_who == 1) begin
            m_if_ready = 1'b1;
            m_if_rdata = val;
        end else begin
            m_dm_ready = 1'b1;
            if (!m_mem_we) m_dm_rdata = val;
        end
        if (tmo) m_err = 1'b1;
    endtask

    always @(posedge clk) begin
        bit ei, ed;
        if (rst) begin
            model_ok = 1'b1;
            m_active = 0; m_who = 0; m_age = 0; m_streak = 0;
            m_err = 0; m_if_ready = 0; m_dm_ready = 0; m_mem_req = 0; m_mem_we = 0;
            m_addr = '0; m_wdata = '0; m_if_rdata = '0; m_dm_rdata = '0;
        end else begin
            ei = if_req && !m_if_ready;
            ed = dm_req && !m_dm_ready;
            m_if_ready = 0;
            m_dm_ready = 0;
            m_mem_req = 0;
            if (!m_active) begin
                if (ed && !(m_streak == SM && ei)) begin
                    m_active = 1; m_who = 2; m_age = 0; m_mem_req = 1;
                    m_mem_we = dm_we; m_addr = dm_addr; m_wdata = dm_wdata;
                    m_streak = ei ? m_streak + 1 : 0;
                end else if (ei) begin
                    m_active = 1; m_who = 1; m_age = 0; m_mem_req = 1;
                    m_mem_we = 0; m_addr = if_addr;
                    m_streak = 0;
                end
            end else if (m_age > 0 && mem_ready) begin
                modelFinish(mem_rdata, 1'b0);
            end else if (m_age == TO + 1) begin
                modelFinish('0, 1'b1);
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            checkOutput("cmp_mem_req", 32'(mem_req), 32'(m_mem_req));
            checkOutput("cmp_mem_we", 32'(mem_we), 32'(m_mem_we));
            checkOutput("cmp_mem_addr", 32'(mem_addr), 32'(m_addr));
            checkOutput("cmp_mem_wdata", mem_wdata, m_wdata);
            checkOutput("cmp_if_ready", 32'(if_ready), 32'(m_if_ready));
            checkOutput("cmp_if_rdata", if_rdata, m_if_rdata);
            checkOutput("cmp_dm_ready", 32'(dm_ready), 32'(m_dm_ready));
            checkOutput("cmp_dm_rdata", dm_rdata, m_dm_rdata);
            checkOutput("cmp_busy", 32'(busy), 32'(m_active));
            checkOutput("cmp_timeout_err", 32'(timeout_err), 32'(m_err));
        end
    end

    // Memory responder: 0 = bench drives mem_ready directly, 1 = fixed latency, 2 = random.
    int          mem_mode = 0;
    int          fix_lat = 1;
    int          cd = 0;
    int          stall = 0;
    logic [DW-1:0] resp_data = '0;

    always @(negedge clk) begin
        if (mem_mode == 1) begin
            mem_ready = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    mem_ready = 1'b1;
                    mem_rdata = resp_data;
                end
            end
            if (mem_req) cd = fix_lat;
        end else if (mem_mode == 2) begin
            cd = 0;
            mem_rdata = $urandom;
            if (stall > 0) begin
                stall--;
                mem_ready = 1'b0;
            end else begin
                mem_ready = ($urandom % 4 == 0);
                if ($urandom % 120 == 0) stall = TO + 4;
            end
        end else begin
            cd = 0;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst = 1'b1;
        mem_mode = 0;
        if_req = 0; dm_req = 0; dm_we = 0; mem_ready = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // sel: 0 = if_ready, 1 = dm_ready, 2 = mem_req
    task automatic waitFor(input int sel, input int maxc, input string name, output int cycles);
        bit seen = 0;
        cycles = 0;
        while (!seen && cycles < maxc) begin
            tick();
            cycles++;
            case (sel)
                0: seen = if_ready;
                1: seen = dm_ready;
                default: seen = mem_req;
            endcase
        end
        if (!seen) checkOutput(name, 32'(0), 32'(1));
    endtask

    task automatic applyStimulus();
        rst = ($urandom % 300 == 0);
        if (!if_req || if_ready) begin
            if_req = ($urandom % 3 != 0);
            if_addr = AW'($urandom);
        end else if ($urandom % 64 == 0) begin
            if_req = 1'b0;
        end
        if (!dm_req || dm_ready) begin
            dm_req = ($urandom % 2 == 0);
            dm_we = $urandom % 2;
            dm_addr = AW'($urandom);
            dm_wdata = $urandom;
        end else if ($urandom % 64 == 0) begin
            dm_req = 1'b0;
        end
    endtask

    initial begin
        int n, c_dm, c_ifreq, c_if;
        logic [AW-1:0] grants[$];
        logic [AW-1:0] exp_grants[7];

        // Reset with a live request and a stray memory completion.
        rst = 1'b1; if_req = 1; if_addr = 10'h003; dm_req = 0; dm_we = 0;
        dm_addr = '0; dm_wdata = '0; mem_ready = 1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) tick();
        checkOutput("rst_mem_req", 32'(mem_req), 32'(0));
        checkOutput("rst_if_ready", 32'(if_ready), 32'(0));
        checkOutput("rst_busy", 32'(busy), 32'(0));
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'(0));
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'(0));
        checkOutput("rst_if_rdata", if_rdata, 32'(0));
        rst = 1'b0; mem_ready = 0;
        tick();
        checkOutput("first_mem_req", 32'(mem_req), 32'(1));
        checkOutput("first_mem_addr", 32'(mem_addr), 32'h003);

        // Single fetch with memory latency 2.
        doReset();
        if_req = 1; if_addr = 10'h004;
        tick();
        checkOutput("fetch_mem_req_c1", 32'(mem_req), 32'(1));
        checkOutput("fetch_mem_addr_c1", 32'(mem_addr), 32'h004);
        checkOutput("fetch_busy_c1", 32'(busy), 32'(1));
        tick();
        checkOutput("fetch_mem_req_c2", 32'(mem_req), 32'(0));
        checkOutput("fetch_busy_c2", 32'(busy), 32'(1));
        tick();
        checkOutput("fetch_busy_c3", 32'(busy), 32'(1));
        checkOutput("fetch_if_ready_c3", 32'(if_ready), 32'(0));
        mem_ready = 1; mem_rdata = 32'h8C22_0000;
        tick();
        checkOutput("fetch_if_ready_c4", 32'(if_ready), 32'(1));
        checkOutput("fetch_if_rdata_c4", if_rdata, 32'h8C22_0000);
        checkOutput("fetch_busy_c4", 32'(busy), 32'(0));
        mem_ready = 0; if_req = 0;
        tick();
        checkOutput("fetch_if_ready_c5", 32'(if_ready), 32'(0));

        // Simultaneous load and fetch, latency 1: data first, fetch right behind.
        doReset();
        mem_mode = 1; fix_lat = 1; resp_data = 32'h0BAD_F00D;
        dm_req = 1; dm_we = 0; dm_addr = 10'h010; if_req = 1; if_addr = 10'h008;
        c_dm = -1; c_ifreq = -1; c_if = -1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (mem_req && mem_addr == 10'h008 && c_ifreq < 0) c_ifreq = k;
            if (dm_ready && c_dm < 0) begin c_dm = k; dm_req = 0; end
            if (if_ready && c_if < 0) begin c_if = k; if_req = 0; end
        end
        checkOutput("simul_dm_ready_cycle", 32'(c_dm), 32'(3));
        checkOutput("simul_if_mem_req_cycle", 32'(c_ifreq), 32'(4));
        checkOutput("simul_if_ready_cycle", 32'(c_if), 32'(6));

        // Starvation guard: fetch drops its request only during data ready cycles.
        doReset();
        mem_mode = 1; fix_lat = 1;
        dm_req = 1; dm_we = 0; dm_addr = 10'h200; if_req = 1; if_addr = 10'h100;
        exp_grants = '{10'h200, 10'h200, 10'h100, 10'h200, 10'h200, 10'h200, 10'h100};
        n = 0;
        while (grants.size() < 7 && n < 200) begin
            tick();
            n++;
            if (mem_req) grants.push_back(mem_addr);
            if_req = !dm_ready;
        end
        checkOutput("starve_grant_count", 32'(grants.size()), 32'(7));
        for (int k = 0; k < 7 && k < grants.size(); k++)
            checkOutput($sformatf("starve_grant_%0d", k), 32'(grants[k]), 32'(exp_grants[k]));
        dm_req = 0; if_req = 0;

        // Store leaves dm_rdata holding the previous load result.
        doReset();
        mem_mode = 1; fix_lat = 2; resp_data = 32'hCAFE_F00D;
        dm_req = 1; dm_we = 0; dm_addr = 10'h030;
        waitFor(1, 40, "load_ready_bound", n);
        checkOutput("load_dm_rdata", dm_rdata, 32'hCAFE_F00D);
        dm_req = 0;
        tick();
        resp_data = 32'h5555_AAAA;
        dm_req = 1; dm_we = 1; dm_addr = 10'h020; dm_wdata = 32'h1234_5678;
        waitFor(2, 40, "store_mem_req_bound", n);
        checkOutput("store_mem_we", 32'(mem_we), 32'(1));
        checkOutput("store_mem_addr", 32'(mem_addr), 32'h020);
        checkOutput("store_mem_wdata", mem_wdata, 32'h1234_5678);
        waitFor(1, 40, "store_ready_bound", n);
        checkOutput("store_dm_rdata", dm_rdata, 32'hCAFE_F00D);
        dm_req = 0; dm_we = 0;

        // Timeout on a silent memory, then reset in the middle of a data wait.
        doReset();
        mem_mode = 1; fix_lat = 1; resp_data = 32'hDEAD_BEEF;
        dm_req = 1; dm_addr = 10'h040;
        waitFor(1, 40, "pre_tmo_ready_bound", n);
        dm_req = 0;
        mem_mode = 0; mem_ready = 0;
        tick();
        dm_req = 1; dm_addr = 10'h044;
        tick();
        checkOutput("tmo_mem_req", 32'(mem_req), 32'(1));
        n = 0;
        for (int k = 1; k <= TO + 1; k++) begin
            tick();
            if (dm_ready || timeout_err) n++;
        end
        checkOutput("tmo_no_early_ready", 32'(n), 32'(0));
        tick();
        checkOutput("tmo_dm_ready", 32'(dm_ready), 32'(1));
        checkOutput("tmo_dm_rdata", dm_rdata, 32'(0));
        checkOutput("tmo_err_set", 32'(timeout_err), 32'(1));
        dm_req = 0;
        tick();
        checkOutput("tmo_err_sticky", 32'(timeout_err), 32'(1));
        dm_req = 1; dm_addr = 10'h050;
        tick();
        tick();
        checkOutput("mid_busy_before_rst", 32'(busy), 32'(1));
        rst = 1; dm_req = 0;
        tick();
        rst = 0;
        checkOutput("mid_rst_busy", 32'(busy), 32'(0));
        checkOutput("mid_rst_err", 32'(timeout_err), 32'(0));
        checkOutput("mid_rst_mem_addr", 32'(mem_addr), 32'(0));
        mem_ready = 1; mem_rdata = 32'h7777_7777;
        tick();
        mem_ready = 0;
        tick();
        checkOutput("late_ready_no_dm_pulse", 32'(dm_ready), 32'(0));
        checkOutput("late_ready_no_if_pulse", 32'(if_ready), 32'(0));

        // Random traffic against the reference model.
        doReset();
        mem_mode = 2;
        for (int k = 0; k < 4000; k++) begin
            applyStimulus();
            tick();
        end
        mem_mode = 0; rst = 1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
